dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory port between the pipeline MEM stage (port 0) and the debug/DMA loader (port 1). It accepts one request per cycle, drives the memory's read/write enables, and returns one response per accepted request exactly one cycle later, matching the memory's registered read latency. It also rejects misaligned and out-of-range addresses without touching memory. It sits between the pipeline/debug masters and `data_memory`.

## Interface
- `MEM_SIZE`, 256, memory depth in 32-bit words; legal word index 0..MEM_SIZE-1
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req0_valid_i`, `req1_valid_i`  in  1  request valid, port 0 / port 1
- `req0_ready_o`, `req1_ready_o`  out  1  request accepted (grant) this cycle
- `req0_we_i`, `req1_we_i`  in  1  1 = write, 0 = read
- `req0_addr_i`, `req1_addr_i`  in  32  byte address
- `req0_wdata_i`, `req1_wdata_i`  in  32  write data
- `rsp0_valid_o`, `rsp1_valid_o`  out  1  one-cycle response pulse
- `rsp0_err_o`, `rsp1_err_o`  out  1  request rejected; qualified by rsp valid
- `rsp0_rdata_o`, `rsp1_rdata_o`  out  32  read data; 0 for writes and errors
- `mem_addr_o`  out  32  to memory address
- `mem_write_data_o`  out  32  to memory write data
- `mem_read_en_o`  out  1  to memory read enable
- `mem_write_en_o`  out  1  to memory write enable
- `mem_read_data_i`  in  32  memory registered read data, valid cycle after read enable

## Operation
- Grant is combinational from this cycle's valids. At most one ready is high per cycle; ready is never high without its valid.
- Requesters hold valid, we, addr, and wdata stable until ready. No outstanding limit: a new grant is allowed every cycle.
- An accepted request is an error if `addr[1:0] != 0` or `addr[31:2] >= MEM_SIZE`.
  - Error requests assert neither memory enable.
- An accepted, non-error request drives the memory outputs:
  - `mem_addr_o` = granted addr.
  - Read: `mem_read_en_o` = 1.
  - Write: `mem_write_en_o` = 1 and `mem_write_data_o` = wdata.
- With no grant, all memory enables are 0. `mem_addr_o` and `mem_write_data_o` are 0.
- Response tracking registers, captured at the grant cycle: `rsp_pend`, `rsp_port`, `rsp_is_read`, `rsp_err`.
- Cycle after grant:
  - The granted port's `rsp_valid` = 1 and `rsp_err` = captured error.
  - `rsp_rdata` = `mem_read_data_i` for a non-error read; 0 otherwise.
  - The other port's response outputs stay 0.
- Arbitration policy is set per Configuration.

## Timing
- Grant/ready: cycle N, combinational. Memory enable: cycle N. Response: cycle N+1, for reads, writes and errors alike.
- Back-to-back: a grant at N+1 overlaps the response for N. Throughput is one request per cycle.
- Reset (`rst` = 1 at a rising edge):
  - All ready, rsp valid/err/rdata and memory enables are 0 during and after reset.
  - `rsp_pend` is cleared, so a response pending across reset is dropped, never delivered.
  - Round-robin pointer resets to "port 0 preferred".
- Requests presented while `rst` = 1 are not granted.
- A write and a later read to the same address in consecutive cycles: the read returns the new data, because the memory write lands at edge N+1 before the read sample at edge N+2.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin policy with a 1-bit `last_grant` register, updated on every grant.
  - When both ports are valid, grant the port not granted last.
  - When a single port is valid, it is granted regardless of the pointer.
- `DMEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, port 0 always wins. Port 1 is granted only when `req0_valid_i` = 0.
  - No pointer register exists.

## Test plan
- **Reset:** hold `rst` = 1 for 3 cycles with both valids high. Required: all ready, rsp and memory enables stay 0. Release reset: first grant goes to port 0.
- **Single port write then read:** port 0 writes 0xDEADBEEF at 0x10. Required: `mem_write_en_o` = 1 with `mem_addr_o` = 0x10 at N, and `rsp0_valid_o` = 1, `rsp0_rdata_o` = 0 at N+1. Then port 0 reads 0x10 at N+1. Required: `rsp0_rdata_o` = 0xDEADBEEF at N+2, err = 0.
- **Contention:** both ports continuously issue reads for 4 cycles.
  - Round-robin build: grants go 0,1,0,1, and responses arrive on matching ports one cycle later.
  - Fixed build: grants go 0,0,0,0, and `req1_ready_o` stays 0.
- **Errors:**
  - Port 1 reads 0x00000402 (misaligned). Required: no memory enable; `rsp1_valid_o` = 1, `rsp1_err_o` = 1, rdata = 0 next cycle.
  - Port 1 writes 0x00000400 (index 256 with `MEM_SIZE` = 256). Required: `rsp1_err_o` = 1 and no write.
- **Reset mid-operation:** port 0 read granted at N, `rst` = 1 at edge N+1. Required: `rsp0_valid_o` = 0 at N+1 and after.
- **Back-to-back alternating:** port 0 writes 0x1 to 0x0, port 1 reads 0x0 the next cycle. Required: `rsp1_rdata_o` = 0x1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the pipeline MEM stage
// (port 0) and the debug/DMA loader (port 1). One grant per cycle, one
// response per grant exactly one cycle later. Misaligned or out-of-range
// requests are answered with an error and never reach the memory.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic        req0_we_i,
    input  logic        req1_we_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic [31:0] req1_wdata_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    output logic        rsp0_err_o,
    output logic        rsp1_err_o,
    output logic [31:0] rsp0_rdata_o,
    output logic [31:0] rsp1_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_write_data_o,
    output logic        mem_read_en_o,
    output logic        mem_write_en_o,
    input  logic [31:0] mem_read_data_i
);

    localparam logic [29:0] MemWords = 30'(MEM_SIZE);

    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    logic        rsp_pend;
    logic        rsp_port;
    logic        rsp_is_read;
    logic        rsp_err;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // last_grant = 1 means port 1 was granted last, so port 0 is preferred next.
    logic last_grant;

    // Round-robin grant: on contention pick the port not granted last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    // Pointer follows every grant; reset leaves port 0 preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end
`else
    // Fixed priority grant: port 1 only when port 0 is idle.
    always_comb begin
        gnt0 = !rst && req0_valid_i;
        gnt1 = !rst && req1_valid_i && !req0_valid_i;
    end
`endif

    // Select the granted request and classify it.
    always_comb begin
        any_gnt   = gnt0 || gnt1;
        sel_we    = gnt1 ? req1_we_i    : req0_we_i;
        sel_addr  = gnt1 ? req1_addr_i  : req0_addr_i;
        sel_wdata = gnt1 ? req1_wdata_i : req0_wdata_i;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= MemWords);
    end

    // Drive readies and the memory port; errors leave the memory untouched.
    always_comb begin
        req0_ready_o     = gnt0;
        req1_ready_o     = gnt1;
        mem_addr_o       = 32'd0;
        mem_write_data_o = 32'd0;
        mem_read_en_o    = 1'b0;
        mem_write_en_o   = 1'b0;
        if (any_gnt && !sel_err) begin
            mem_addr_o = sel_addr;
            if (sel_we) begin
                mem_write_en_o   = 1'b1;
                mem_write_data_o = sel_wdata;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    // Capture response tracking at the grant cycle; reset drops anything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend    <= 1'b0;
            rsp_port    <= 1'b0;
            rsp_is_read <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_pend    <= any_gnt;
            rsp_port    <= gnt1;
            rsp_is_read <= !sel_we;
            rsp_err     <= sel_err;
        end
    end

    // Route the response to the port that was granted last cycle.
    always_comb begin
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp0_err_o   = 1'b0;
        rsp1_err_o   = 1'b0;
        rsp0_rdata_o = 32'd0;
        rsp1_rdata_o = 32'd0;
        // Gated by rst so nothing leaks out while reset is asserted.
        if (rsp_pend && !rst) begin
            if (rsp_port) begin
                rsp1_valid_o = 1'b1;
                rsp1_err_o   = rsp_err;
                rsp1_rdata_o = (rsp_is_read && !rsp_err) ? mem_read_data_i : 32'd0;
            end else begin
                rsp0_valid_o = 1'b1;
                rsp0_err_o   = rsp_err;
                rsp0_rdata_o = (rsp_is_read && !rsp_err) ? mem_read_data_i : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data_memory
// (registered read) and a response scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic        req0_we_i, req1_we_i;
    logic [31:0] req0_addr_i, req1_addr_i;
    logic [31:0] req0_wdata_i, req1_wdata_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_err_o, rsp1_err_o;
    logic [31:0] rsp0_rdata_o, rsp1_rdata_o;
    logic [31:0] mem_addr_o, mem_write_data_o;
    logic        mem_read_en_o, mem_write_en_o;
    logic [31:0] mem_read_data_i;

    dmem_arbiter #(.MEM_SIZE(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid_i     (req0_valid_i),
        .req1_valid_i     (req1_valid_i),
        .req0_ready_o     (req0_ready_o),
        .req1_ready_o     (req1_ready_o),
        .req0_we_i        (req0_we_i),
        .req1_we_i        (req1_we_i),
        .req0_addr_i      (req0_addr_i),
        .req1_addr_i      (req1_addr_i),
        .req0_wdata_i     (req0_wdata_i),
        .req1_wdata_i     (req1_wdata_i),
        .rsp0_valid_o     (rsp0_valid_o),
        .rsp1_valid_o     (rsp1_valid_o),
        .rsp0_err_o       (rsp0_err_o),
        .rsp1_err_o       (rsp1_err_o),
        .rsp0_rdata_o     (rsp0_rdata_o),
        .rsp1_rdata_o     (rsp1_rdata_o),
        .mem_addr_o       (mem_addr_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_write_en_o   (mem_write_en_o),
        .mem_read_data_i  (mem_read_data_i)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: write at the edge, registered read data.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_write_en_o) mem[mem_addr_o[9:2]] <= mem_write_data_o;
        if (mem_read_en_o) mem_read_data_i <= mem[mem_addr_o[9:2]];
    end

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] shadow [256];
    logic        exp_last = 1'b1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: at negedge check responses, then grant/memory outputs.
    task automatic step();
        logic        g0, g1, we, err;
        logic [31:0] addr, wdata;
        rsp_t        e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            check("rsp0_valid_rst", rsp0_valid_o, 1'b0);
            check("rsp1_valid_rst", rsp1_valid_o, 1'b0);
            check("rsp0_rdata_rst", rsp0_rdata_o, 32'd0);
            check("rsp1_err_rst", rsp1_err_o, 1'b0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp0_valid", rsp0_valid_o, !e.port);
            check("rsp1_valid", rsp1_valid_o, e.port);
            check("rsp_err", e.port ? rsp1_err_o : rsp0_err_o, e.err);
            check("rsp_rdata", e.port ? rsp1_rdata_o : rsp0_rdata_o, e.rdata);
        end else begin
            check("rsp0_idle", rsp0_valid_o, 1'b0);
            check("rsp1_idle", rsp1_valid_o, 1'b0);
        end

        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (req0_valid_i && req1_valid_i) begin
                g0 = exp_last;
                g1 = !exp_last;
            end else begin
                g0 = req0_valid_i;
                g1 = req1_valid_i;
            end
`else
            g0 = req0_valid_i;
            g1 = req1_valid_i && !req0_valid_i;
`endif
        end
        check("req0_ready", req0_ready_o, g0);
        check("req1_ready", req1_ready_o, g1);

        we    = g1 ? req1_we_i : req0_we_i;
        addr  = g1 ? req1_addr_i : req0_addr_i;
        wdata = g1 ? req1_wdata_i : req0_wdata_i;
        err   = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
        if (g0 || g1) begin
            check("mem_read_en", mem_read_en_o, !err && !we);
            check("mem_write_en", mem_write_en_o, !err && we);
            check("mem_addr", mem_addr_o, err ? 32'd0 : addr);
            check("mem_wdata", mem_write_data_o, (!err && we) ? wdata : 32'd0);
            e.port  = g1;
            e.err   = err;
            e.rdata = (!err && !we) ? shadow[addr[9:2]] : 32'd0;
            sb.push_back(e);
            if (!err && we) shadow[addr[9:2]] = wdata;
            exp_last = g1;
        end else begin
            check("mem_read_en_idle", mem_read_en_o, 1'b0);
            check("mem_write_en_idle", mem_write_en_o, 1'b0);
            check("mem_addr_idle", mem_addr_o, 32'd0);
        end
        if (rst) exp_last = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            req0_valid_i = v; req0_we_i = we; req0_addr_i = addr; req0_wdata_i = wdata;
        end else begin
            req1_valid_i = v; req1_we_i = we; req1_addr_i = addr; req1_wdata_i = wdata;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        mem_read_data_i = 32'd0;
        idle();
        rst = 1'b1;
        #1;

        // Reset with both ports requesting.
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h24, 32'd0);
        repeat (3) step();

        // Contention straight out of reset.
        rst = 1'b0;
        repeat (4) step();
        idle();
        step();

        // Write then read on port 0.
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        step();
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        step();
        idle();
        step();

        // Misaligned read and out-of-range write on port 1, then prove no write landed.
        drive(1, 1'b1, 1'b0, 32'h402, 32'd0);
        step();
        drive(1, 1'b1, 1'b1, 32'h400, 32'hBAD0BAD0);
        step();
        drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
        step();
        idle();
        step();

        // Reset while a read response is pending.
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        step();
        idle();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Back-to-back alternating write/read through different ports.
        drive(0, 1'b1, 1'b1, 32'h0, 32'h1);
        step();
        idle();
        drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
        step();
        idle();
        step();

        // Random traffic, including occasional illegal addresses.
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] a;
                a = 32'($urandom_range(0, 259)) << 2;
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            end
            step();
        end
        idle();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
